hcms_disp_sched: RTL

- Scheduler and configurator in front of the HCMS29xx serial LED driver; shares one multi-unit dot-matrix display between NREQ frame producers.
- Round-robin arbitration between producers, with a minimum dwell time per owner.
- Drives the driver's parallel frame bus and control word (CW0: 0 S I I P P P P).
- Fades brightness out and back in across owner switches, and sequences sleep entry/exit.

---
 rtl/hcms_disp_sched.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hcms_disp_sched.sv
// HCMS29xx display scheduler: round-robin owner arbitration with dwell,
// brightness fade across owner switches, and sleep sequencing.
module hcms_disp_sched #(
  parameter int         N         = 2,
  parameter int         UNIT_W    = 20,
  parameter int         UNIT_H    = 8,
  parameter int         NREQ      = 2,
  parameter logic [1:0] PEAK      = 2'b10,
  parameter int         FADE_STEP = 64,
  parameter int         HOLD_MIN  = 4096,
  localparam int        FW = N * UNIT_W * UNIT_H,
  localparam int        RW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*FW-1:0] req_frame,
  input  logic [NREQ*4-1:0]  req_pwm,
  input  logic               sleep_req,
  output logic [FW-1:0]      frame_out,
  output logic [7:0]         pcmd_out,
  output logic [RW-1:0]      owner,
  output logic               update_strobe,
  output logic               busy
);

  localparam int TW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam int DW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FADE_OUT, S_SWAP, S_FADE_IN, S_DWELL, S_SLEEP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      pwm_q, pwm_d;
  logic [3:0]      tgt_q, tgt_d;
  logic [RW-1:0]   own_q, own_d;
  logic [RW-1:0]   sel_q, sel_d;
  logic            pend_q, pend_d;
  logic            s_q, s_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [NREQ-1:0] rdy_q, rdy_d;
  logic            stb_q, stb_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   dwl_q, dwl_d;

  logic [RW-1:0]   win;
  logic            found;
  logic            tick;
  logic [3:0]      stp;

  function automatic logic [3:0] toward(
    input logic [3:0] c,
    input logic [3:0] t
  );
    if (c < t) return c + 4'd1;
    if (c > t) return c - 4'd1;
    return c;
  endfunction

  // Search owner+1, owner+2, ...; the owner itself comes last.
  always_comb begin
    int idx;
    win   = own_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(own_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = RW'(idx);
      end
    end
  end

  assign tick = (tmr_q == TW'(FADE_STEP - 1));
  assign stp  = toward(pwm_q, tgt_q);

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    tgt_d   = tgt_q;
    own_d   = own_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    s_d     = s_q;
    frame_d = frame_q;
    rdy_d   = '0;
    dwl_d   = dwl_q;
    // The ready cycle is when the requester's data is taken.
    if (|rdy_q) begin
      frame_d = req_frame[int'(sel_q)*FW +: FW];
      tgt_d   = req_pwm[int'(sel_q)*4 +: 4];
      own_d   = sel_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (sleep_req) begin
          state_d = S_FADE_OUT;
          pend_d  = 1'b0;
        end else if (|rdy_q) begin
          state_d = S_FADE_IN;
        end else if (found) begin
          sel_d = win;
          if (win == own_q || pwm_q == 4'd0) begin
            rdy_d[win] = 1'b1;
          end else begin
            pend_d  = 1'b1;
            state_d = S_FADE_OUT;
          end
        end
      end
      S_FADE_OUT: begin
        if (pwm_q == 4'd0) begin
          if (sleep_req) begin
            state_d = S_SLEEP;
            s_d     = 1'b0;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            state_d      = S_SWAP;
            rdy_d[sel_q] = 1'b1;
            pend_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick) begin
          pwm_d = pwm_q - 4'd1;
        end
      end
      S_SWAP: state_d = S_FADE_IN;
      S_FADE_IN: begin
        if (sleep_req) begin
          state_d = S_FADE_OUT;
          pend_d  = 1'b0;
        end else if (pwm_q == tgt_q) begin
          state_d = S_DWELL;
          dwl_d   = '0;
        end else if (tick) begin
          pwm_d = stp;
          if (stp == tgt_q) begin
            state_d = S_DWELL;
            dwl_d   = '0;
          end
        end
      end
      S_DWELL: begin
        if (sleep_req) begin
          state_d = S_FADE_OUT;
          pend_d  = 1'b0;
        end else begin
          dwl_d = dwl_q + 1'b1;
          if (tick) pwm_d = stp;
          if (dwl_q == DW'(HOLD_MIN - 1)) begin
            state_d = S_IDLE;
          end else if (req_valid[own_q] && !(|rdy_q)) begin
            rdy_d[own_q] = 1'b1;
            sel_d        = own_q;
          end
        end
      end
      S_SLEEP: begin
        if (!sleep_req) begin
          s_d     = 1'b1;
          state_d = S_FADE_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_d  = (state_d != state_q || tick) ? '0 : tmr_q + 1'b1;
  assign stb_d  = (frame_d != frame_q) || (pwm_d != pwm_q) ||
                  (s_d != s_q);
  assign busy_d = (state_d == S_FADE_OUT) || (state_d == S_SWAP) ||
                  (state_d == S_FADE_IN) || (state_d == S_SLEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pwm_q   <= '0;
      tgt_q   <= '0;
      own_q   <= '0;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      s_q     <= 1'b1;
      frame_q <= '0;
      rdy_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmr_q   <= '0;
      dwl_q   <= '0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      tgt_q   <= tgt_d;
      own_q   <= own_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      s_q     <= s_d;
      frame_q <= frame_d;
      rdy_q   <= rdy_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      tmr_q   <= tmr_d;
      dwl_q   <= dwl_d;
    end
  end

  assign frame_out     = frame_q;
  assign pcmd_out      = {1'b0, s_q, PEAK, pwm_q};
  assign owner         = own_q;
  assign req_ready     = rdy_q;
  assign update_strobe = stb_q;
  assign busy          = busy_q;

endmodule
